// File: rtl/dmem_mmio_pkg.sv
// -----------------------------------------------------------------------------
// dmem_mmio_pkg
// Shared definitions for the data-memory / MMIO responder:
//   - default base address of the 256-byte I/O page
//   - register byte offsets and their word indices (addr[7:2])
//   - STATUS register bit positions
//   - byte-lane indices (big-endian: lane 0 = bits 7:0 = byte offset 3)
//   - register-select enum plus a decode helper
//   - TXDATA lane-priority byte selection helper
// -----------------------------------------------------------------------------
package dmem_mmio_pkg;

    localparam logic [31:0] MMIO_BASE_DEFAULT = 32'hFFFF_FF00;

    // Register byte offsets inside the I/O page
    localparam logic [7:0] OFF_TXDATA = 8'h00;
    localparam logic [7:0] OFF_STATUS = 8'h04;
    localparam logic [7:0] OFF_CYCLE  = 8'h08;

    // Word indices as seen on addr[7:2]
    localparam logic [5:0] REG_TXDATA = OFF_TXDATA[7:2];
    localparam logic [5:0] REG_STATUS = OFF_STATUS[7:2];
    localparam logic [5:0] REG_CYCLE  = OFF_CYCLE[7:2];

    // STATUS = {16'b0, count[7:0], 5'b0, ovf, full, empty}
    localparam int STAT_EMPTY     = 0;
    localparam int STAT_FULL      = 1;
    localparam int STAT_OVF       = 2;
    localparam int STAT_COUNT_LSB = 8;

    // Byte lanes: we[i] covers wdata[8*i +: 8]; big-endian byte offsets
    localparam int LANE_OFF3 = 0;  // bits  7:0
    localparam int LANE_OFF2 = 1;  // bits 15:8
    localparam int LANE_OFF1 = 2;  // bits 23:16
    localparam int LANE_OFF0 = 3;  // bits 31:24

    typedef enum logic [1:0] {
        SEL_NONE,
        SEL_TXDATA,
        SEL_STATUS,
        SEL_CYCLE
    } mmio_sel_e;

    function automatic mmio_sel_e mmio_decode(input logic [5:0] word_off);
        case (word_off)
            REG_TXDATA: mmio_decode = SEL_TXDATA;
            REG_STATUS: mmio_decode = SEL_STATUS;
            REG_CYCLE:  mmio_decode = SEL_CYCLE;
            default:    mmio_decode = SEL_NONE;
        endcase
    endfunction

    // A byte store from the core arrives on whichever lane matches its
    // offset; the lowest-numbered asserted lane wins so that full-word
    // stores push their least-significant byte.
    function automatic logic [7:0] tx_lane_byte(input logic [3:0]  we,
                                                input logic [31:0] wdata);
        if (we[LANE_OFF3])      tx_lane_byte = wdata[LANE_OFF3*8 +: 8];
        else if (we[LANE_OFF2]) tx_lane_byte = wdata[LANE_OFF2*8 +: 8];
        else if (we[LANE_OFF1]) tx_lane_byte = wdata[LANE_OFF1*8 +: 8];
        else                    tx_lane_byte = wdata[LANE_OFF0*8 +: 8];
    endfunction

endpackage

// File: rtl/dmem_mmio_if.sv
// -----------------------------------------------------------------------------
// dmem_mmio_if
// Bundles the core data port and the byte-stream output of dmem_mmio.
//   addr/wdata/we  : core -> memory, byte address, lane-positioned data, lane WEs
//   rdata          : memory -> core, combinational read data
//   halt           : core -> memory, freezes the cycle counter
//   out_valid/data : memory -> consumer, FIFO head
//   out_ready      : consumer -> memory, accept head this cycle
// Modports: master (core + consumer side, drives requests), slave (dmem_mmio).
// -----------------------------------------------------------------------------
interface dmem_mmio_if;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [3:0]  we;
    logic [31:0] rdata;
    logic        halt;
    logic        out_valid;
    logic [7:0]  out_data;
    logic        out_ready;

    modport master (
        output addr, wdata, we, halt, out_ready,
        input  rdata, out_valid, out_data
    );

    modport slave (
        input  addr, wdata, we, halt, out_ready,
        output rdata, out_valid, out_data
    );
endinterface

// File: rtl/dmem_mmio_tx_fifo.sv
// -----------------------------------------------------------------------------
// dmem_mmio_tx_fifo
// FIFO_DEPTH x 8 output byte FIFO, synchronous push/pop, async active-high rst.
//   clk, rst   : clock, asynchronous active-high reset
//   i_push     : push request (accepted when not full, or full with a pop)
//   i_pop      : pop request (ignored when empty)
//   i_data     : byte to push
//   o_full     : count == FIFO_DEPTH
//   o_empty    : count == 0
//   o_count    : occupancy, 0..FIFO_DEPTH
//   o_head     : oldest byte, 0 while empty
// -----------------------------------------------------------------------------
module dmem_mmio_tx_fifo #(
    parameter int FIFO_DEPTH = 8,
    localparam int PTR_W = $clog2(FIFO_DEPTH),
    localparam int CNT_W = PTR_W + 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             i_push,
    input  logic             i_pop,
    input  logic [7:0]       i_data,
    output logic             o_full,
    output logic             o_empty,
    output logic [CNT_W-1:0] o_count,
    output logic [7:0]       o_head
);
    logic [7:0]       r_mem [FIFO_DEPTH];
    logic [PTR_W-1:0] r_wr_ptr;
    logic [PTR_W-1:0] r_rd_ptr;
    logic [CNT_W-1:0] r_count;

    logic w_pop_ok;
    logic w_push_ok;

    assign o_full    = (r_count == CNT_W'(FIFO_DEPTH));
    assign o_empty   = (r_count == '0);
    assign o_count   = r_count;
    assign w_pop_ok  = i_pop & ~o_empty;
    // A pop frees a slot in the same edge, so a full FIFO can still accept.
    assign w_push_ok = i_push & (~o_full | w_pop_ok);

    // Head is forced to 0 when empty so stale storage never shows after reset.
    assign o_head = o_empty ? 8'h00 : r_mem[r_rd_ptr];

    // NOTE: storage has no reset; only pointers and count define validity,
    // which keeps the array a plain RAM instead of a bank of resettable flops.
    always_ff @(posedge clk) begin
        if (w_push_ok) begin
            r_mem[r_wr_ptr] <= i_data;
        end
    end

    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples pre-edge values regardless of statement order.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            // Pointers wrap naturally: FIFO_DEPTH is a power of two.
            if (w_push_ok) r_wr_ptr <= r_wr_ptr + PTR_W'(1);
            if (w_pop_ok)  r_rd_ptr <= r_rd_ptr + PTR_W'(1);
            case ({w_push_ok, w_pop_ok})
                2'b10:   r_count <= r_count + CNT_W'(1);
                2'b01:   r_count <= r_count - CNT_W'(1);
                default: r_count <= r_count;
            endcase
        end
    end
endmodule

// File: rtl/dmem_mmio.sv
// -----------------------------------------------------------------------------
// dmem_mmio
// Memory-side responder for the core data port: byte-lane data RAM plus a
// 256-byte I/O page holding TXDATA (byte FIFO push), STATUS and CYCLE.
//   clk, rst : clock, asynchronous active-high reset
//   bus      : dmem_mmio_if.slave
//              addr/wdata/we in, rdata out (combinational, zero latency)
//              halt in (freezes CYCLE)
//              out_valid/out_data out, out_ready in (FIFO drain)
// Address map:
//   addr[31:8] == MMIO_BASE[31:8]   -> I/O page, register = addr[7:2]
//   addr[31:ADDR_W+2] == 0          -> RAM word addr[ADDR_W+1:2]
//   anything else                   -> unmapped (reads 0, writes ignored)
// -----------------------------------------------------------------------------
module dmem_mmio
    import dmem_mmio_pkg::*;
#(
    parameter int          ADDR_W     = 10,
    parameter int          FIFO_DEPTH = 8,
    parameter logic [31:0] MMIO_BASE  = MMIO_BASE_DEFAULT
) (
    input logic       clk,
    input logic       rst,
    dmem_mmio_if.slave bus
);
    localparam int CNT_W = $clog2(FIFO_DEPTH) + 1;

    // ---------------------------------------------------------------- decode
    logic              w_mmio_hit;
    logic              w_ram_hit;
    logic [ADDR_W-1:0] w_word;
    mmio_sel_e         w_sel;
    logic              w_any_we;
    logic              w_tx_wr;
    logic              w_status_wr;
    logic              w_cycle_wr;
    logic              w_unused_addr;

    assign w_mmio_hit  = (bus.addr[31:8] == MMIO_BASE[31:8]);
    assign w_ram_hit   = (bus.addr[31:ADDR_W+2] == '0);
    assign w_word      = bus.addr[ADDR_W+1:2];
    assign w_sel       = w_mmio_hit ? mmio_decode(bus.addr[7:2]) : SEL_NONE;
    assign w_any_we    = |bus.we;
    assign w_tx_wr     = (w_sel == SEL_TXDATA) & w_any_we;
    assign w_status_wr = (w_sel == SEL_STATUS) & w_any_we;
    assign w_cycle_wr  = (w_sel == SEL_CYCLE)  & w_any_we;

    // Byte offset within a word does not matter for word-wide reads.
    assign w_unused_addr = &{1'b0, bus.addr[1:0]};

    // ------------------------------------------------------------------- RAM
    logic [31:0] r_mem [2**ADDR_W];

    // Lane writes land at the edge; a same-cycle read still sees old data.
    always_ff @(posedge clk) begin
        if (w_ram_hit) begin
            for (int i = 0; i < 4; i++) begin
                if (bus.we[i]) begin
                    r_mem[w_word][i*8 +: 8] <= bus.wdata[i*8 +: 8];
                end
            end
        end
    end

    // ------------------------------------------------------------ output FIFO
    logic             w_pop;
    logic             w_full;
    logic             w_empty;
    logic [CNT_W-1:0] w_count;
    logic [7:0]       w_head;
    logic [7:0]       w_tx_byte;

    assign w_pop     = ~w_empty & bus.out_ready;
    assign w_tx_byte = tx_lane_byte(bus.we, bus.wdata);

    dmem_mmio_tx_fifo #(
        .FIFO_DEPTH (FIFO_DEPTH)
    ) u_tx_fifo (
        .clk     (clk),
        .rst     (rst),
        .i_push  (w_tx_wr),
        .i_pop   (w_pop),
        .i_data  (w_tx_byte),
        .o_full  (w_full),
        .o_empty (w_empty),
        .o_count (w_count),
        .o_head  (w_head)
    );

    assign bus.out_valid = ~w_empty;
    assign bus.out_data  = w_head;

    // --------------------------------------------------------- overflow flag
    logic r_ovf;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_ovf <= 1'b0;
        end else if (w_status_wr) begin
            r_ovf <= 1'b0;
        end else if (w_tx_wr & w_full & ~w_pop) begin
            // Push into a full FIFO with no slot freed: byte is dropped.
            r_ovf <= 1'b1;
        end
    end

    // --------------------------------------------------------- cycle counter
    logic [31:0] r_cycle;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_cycle <= '0;
        end else if (w_cycle_wr) begin
            r_cycle <= '0;
        end else if (~bus.halt) begin
            r_cycle <= r_cycle + 32'd1;
        end
    end

    // ------------------------------------------------------------ read mux
    logic [31:0] w_status;

    // NOTE: every always_comb output gets a default first so no path leaves
    // it unassigned, which would otherwise infer a latch.
    always_comb begin
        w_status                          = '0;
        w_status[STAT_EMPTY]              = w_empty;
        w_status[STAT_FULL]               = w_full;
        w_status[STAT_OVF]                = r_ovf;
        w_status[STAT_COUNT_LSB +: 8]     = 8'(w_count);
    end

    always_comb begin
        bus.rdata = '0;
        if (w_ram_hit) begin
            bus.rdata = r_mem[w_word];
        end else begin
            case (w_sel)
                SEL_STATUS: bus.rdata = w_status;
                SEL_CYCLE:  bus.rdata = r_cycle;
                default:    bus.rdata = '0;   // TXDATA is write-only
            endcase
        end
    end
endmodule

// File: tb/tb_dmem_mmio.sv
// -----------------------------------------------------------------------------
// tb_dmem_mmio
// Self-checking bench for dmem_mmio. A behavioural model (word array, byte
// queue, overflow bit, cycle integer) is stepped once per cycle from the bus
// inputs; a monitor compares rdata/out_valid/out_data against it on every
// falling edge. Directed sequences add literal expectations, then a
// randomized phase mixes RAM, MMIO and unmapped traffic.
// -----------------------------------------------------------------------------
module tb_dmem_mmio;
    localparam logic [31:0] BASE   = 32'hFFFF_FF00;
    localparam logic [31:0] A_TX   = BASE + 32'h00;
    localparam logic [31:0] A_ST   = BASE + 32'h04;
    localparam logic [31:0] A_CYC  = BASE + 32'h08;
    localparam logic [31:0] A_IDLE = BASE + 32'h40;
    localparam logic [31:0] A_UNM  = 32'h0001_0000;
    localparam int          DEPTH  = 8;

    logic clk = 1'b0;
    logic rst = 1'b1;

    dmem_mmio_if bus();

    dmem_mmio #(
        .ADDR_W     (10),
        .FIFO_DEPTH (DEPTH),
        .MMIO_BASE  (BASE)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;
    bit mon_en   = 1'b0;

    // ------------------------------------------------------------ model
    logic [31:0] m_mem [1024];
    logic [7:0]  m_q [$];
    bit          m_ovf = 1'b0;
    logic [31:0] m_cyc = 32'h0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%08h, want 0x%08h (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic logic [31:0] m_status();
        return {16'h0, 8'(m_q.size()), 5'h0, m_ovf, (m_q.size() == DEPTH), (m_q.size() == 0)};
    endfunction

    function automatic logic [31:0] m_read(input logic [31:0] a);
        if (a[31:8] == BASE[31:8]) begin
            if (a[7:2] == 6'd1) return m_status();
            if (a[7:2] == 6'd2) return m_cyc;
            return 32'h0;
        end
        if (a[31:12] == 20'h0) return m_mem[a[11:2]];
        return 32'h0;
    endfunction

    // Apply one clock edge worth of architectural effects from the current inputs.
    task automatic m_step();
        logic [31:0] a;
        logic [31:0] d;
        logic [3:0]  w;
        bit          mmio;
        bit          pop;
        bit          was_full;
        logic [7:0]  b;
        a        = bus.addr;
        d        = bus.wdata;
        w        = bus.we;
        mmio     = (a[31:8] == BASE[31:8]);
        was_full = (m_q.size() == DEPTH);
        pop      = (m_q.size() != 0) && bus.out_ready;
        if (pop) void'(m_q.pop_front());
        if (mmio && a[7:2] == 6'd0 && w != 4'h0) begin
            b = 8'h00;
            for (int i = 3; i >= 0; i--) if (w[i]) b = d[8*i +: 8];
            if (!was_full || pop) m_q.push_back(b);
            else                  m_ovf = 1'b1;
        end
        if (mmio && a[7:2] == 6'd1 && w != 4'h0) m_ovf = 1'b0;
        if (mmio && a[7:2] == 6'd2 && w != 4'h0) m_cyc = 32'h0;
        else if (!bus.halt)                      m_cyc = m_cyc + 32'd1;
        if (a[31:12] == 20'h0) begin
            for (int i = 0; i < 4; i++) if (w[i]) m_mem[a[11:2]][8*i +: 8] = d[8*i +: 8];
        end
    endtask

    always @(posedge rst) begin
        m_q.delete();
        m_ovf = 1'b0;
        m_cyc = 32'h0;
    end

    always @(negedge clk) begin
        if (!rst) begin
            if (mon_en) begin
                check("mon_rdata", bus.rdata, m_read(bus.addr));
                check("mon_out_valid", 32'(bus.out_valid), 32'(m_q.size() != 0));
                if (m_q.size() != 0) check("mon_out_data", 32'(bus.out_data), 32'(m_q[0]));
            end
            m_step();
        end
    end

    // ---------------------------------------------------------- driver helpers
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic wr(input logic [31:0] a, input logic [31:0] d, input logic [3:0] w);
        bus.addr  = a;
        bus.wdata = d;
        bus.we    = w;
        step();
        bus.we    = 4'h0;
        bus.addr  = A_IDLE;
    endtask

    task automatic rd_check(input string name, input logic [31:0] a, input logic [31:0] exp);
        bus.addr = a;
        bus.we   = 4'h0;
        @(negedge clk);
        check(name, bus.rdata, exp);
        step();
        bus.addr = A_IDLE;
    endtask

    task automatic pop_check(input string name, input logic [7:0] exp);
        bus.out_ready = 1'b1;
        @(negedge clk);
        check({name, "_valid"}, 32'(bus.out_valid), 32'h1);
        check(name, 32'(bus.out_data), 32'(exp));
        step();
        bus.out_ready = 1'b0;
    endtask

    task automatic pulse_reset();
        rst = 1'b1;
        #2;
        rst = 1'b0;
    endtask

    // ---------------------------------------------------------------- stimulus
    initial begin
        logic [7:0] drain_exp [8];
        int         r;

        for (int i = 0; i < 1024; i++) m_mem[i] = 32'h0;
        bus.addr      = A_IDLE;
        bus.wdata     = 32'h0;
        bus.we        = 4'h0;
        bus.halt      = 1'b0;
        bus.out_ready = 1'b0;

        repeat (2) @(posedge clk);
        #1;
        check("reset_out_valid", 32'(bus.out_valid), 32'h0);
        check("reset_out_data", 32'(bus.out_data), 32'h0);
        rst = 1'b0;
        rd_check("reset_status", A_ST, 32'h0000_0001);

        // Give the first 64 RAM words defined contents.
        for (int i = 0; i < 64; i++) wr(32'(i * 4), 32'h0, 4'hF);
        mon_en = 1'b1;

        // Cycle counter: 100 free-running cycles, 20 halted, then clear.
        pulse_reset();
        repeat (100) @(posedge clk);
        #1;
        bus.addr = A_CYC;
        bus.halt = 1'b1;
        @(negedge clk);
        check("cyc_after_100", bus.rdata, 32'd100);
        repeat (20) @(posedge clk);
        #1;
        @(negedge clk);
        check("cyc_after_halt", bus.rdata, 32'd100);
        step();
        bus.halt = 1'b0;
        wr(A_CYC, 32'h0, 4'hF);
        rd_check("cyc_after_clear", A_CYC, 32'd0);

        // Byte-lane RAM write.
        wr(32'h10, 32'h1122_3344, 4'b1111);
        wr(32'h12, 32'h0000_AA00, 4'b0010);
        rd_check("ram_lane_0x10", 32'h10, 32'h1122_AA44);
        rd_check("ram_lane_0x13", 32'h13, 32'h1122_AA44);

        // FIFO fill and overflow.
        for (int i = 0; i < 9; i++) wr(A_TX, 32'(8'h41 + i), 4'b0001);
        rd_check("status_full_ovf", A_ST, 32'h0000_0806);
        @(negedge clk);
        check("fifo_head_41", 32'(bus.out_data), 32'h41);
        step();
        wr(A_ST, 32'h0, 4'b1111);
        rd_check("status_ovf_clr", A_ST, 32'h0000_0802);

        // Full FIFO: push and pop in the same cycle.
        bus.addr      = A_TX;
        bus.wdata     = 32'h0000_005A;
        bus.we        = 4'b0001;
        bus.out_ready = 1'b1;
        @(negedge clk);
        check("pushpop_head", 32'(bus.out_data), 32'h41);
        step();
        bus.we        = 4'h0;
        bus.out_ready = 1'b0;
        bus.addr      = A_IDLE;
        rd_check("status_pushpop", A_ST, 32'h0000_0802);
        drain_exp = '{8'h42, 8'h43, 8'h44, 8'h45, 8'h46, 8'h47, 8'h48, 8'h5A};
        for (int i = 0; i < 8; i++) pop_check($sformatf("drain_%0d", i), drain_exp[i]);
        @(negedge clk);
        check("drained_valid", 32'(bus.out_valid), 32'h0);
        step();

        // Lane priority.
        wr(A_TX, 32'h7E00_0000, 4'b1000);
        wr(A_TX, 32'h0102_0304, 4'b1111);
        pop_check("prio_sb", 8'h7E);
        pop_check("prio_word", 8'h04);

        // Asynchronous reset mid-cycle, then unmapped access.
        wr(A_TX, 32'h1, 4'b0001);
        wr(A_TX, 32'h2, 4'b0001);
        wr(A_TX, 32'h3, 4'b0001);
        rd_check("status_three", A_ST, 32'h0000_0300);
        #1;
        rst = 1'b1;
        #1;
        check("async_rst_valid", 32'(bus.out_valid), 32'h0);
        check("async_rst_data", 32'(bus.out_data), 32'h0);
        rst = 1'b0;
        step();
        rd_check("status_after_rst", A_ST, 32'h0000_0001);
        rd_check("unmapped_read", A_UNM, 32'h0);
        wr(A_UNM, 32'hDEAD_BEEF, 4'hF);
        rd_check("unmapped_wr_word0", 32'h0, 32'h0);
        rd_check("unmapped_wr_0x10", 32'h10, 32'h1122_AA44);

        // Randomized traffic; the monitor checks every cycle.
        for (int n = 0; n < 3000; n++) begin
            r             = $urandom_range(0, 99);
            bus.out_ready = (n < 1500) ? ($urandom_range(0, 3) == 0) : ($urandom_range(0, 3) != 0);
            bus.halt      = ($urandom_range(0, 9) == 0);
            bus.wdata     = $urandom;
            bus.we        = 4'h0;
            if (r < 30) begin
                bus.addr = {24'h0, 6'($urandom_range(0, 63)), 2'($urandom_range(0, 3))};
                bus.we   = 4'($urandom_range(0, 15));
            end else if (r < 55) begin
                bus.addr = A_TX;
                bus.we   = 4'($urandom_range(0, 15));
            end else if (r < 60) begin
                bus.addr = A_ST;
                bus.we   = 4'($urandom_range(0, 15));
            end else if (r < 62) begin
                bus.addr = A_CYC;
                bus.we   = 4'($urandom_range(1, 15));
            end else if (r < 75) begin
                bus.addr = BASE | {24'h0, 6'($urandom_range(0, 15)), 2'($urandom_range(0, 3))};
                bus.we   = ($urandom_range(0, 3) == 0) ? 4'($urandom_range(1, 15)) : 4'h0;
            end else if (r < 82) begin
                bus.addr = {20'($urandom_range(1, 20'hFFFFE)), 12'($urandom)};
                bus.we   = 4'($urandom_range(0, 15));
            end else begin
                bus.addr = {24'h0, 6'($urandom_range(0, 63)), 2'($urandom_range(0, 3))};
            end
            step();
        end

        bus.we        = 4'h0;
        bus.addr      = A_IDLE;
        bus.out_ready = 1'b0;
        bus.halt      = 1'b0;
        step();
        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end
endmodule
